// File: rtl/req_arbiter.sv
// Eight-way request arbiter with fixed or round-robin high-index-first selection,
// grant hold until done/withdraw, and a hold-time watchdog that revokes stale grants.
module req_arbiter #(
  parameter int unsigned MAX_HOLD = 255,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  input  logic       rr_en,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [7:0]          gnt_q, gnt_d;
  logic [2:0]          id_q, id_d;
  logic [2:0]          last_q, last_d;
  logic                valid_q, valid_d;
  logic                tmo_q, tmo_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [2:0] base;
  logic [2:0] idx;
  logic [2:0] win_id;
  logic       win_found;
  logic       wd_hit;
  logic       withdraw;

  // Search order is base-1 down to base (mod 8); fixed priority is the base=0 case.
  // Iterating from the far end lets the nearest set bit overwrite earlier hits.
  always_comb begin
    base      = rr_en ? last_q : 3'd0;
    idx       = '0;
    win_id    = '0;
    win_found = 1'b0;
    for (int k = 8; k >= 1; k--) begin
      idx = base - 3'(k);
      if (req[idx]) begin
        win_id    = idx;
        win_found = 1'b1;
      end
    end
  end

  assign wd_hit   = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));
  assign withdraw = !req[id_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    valid_d = valid_q;
    last_d  = last_q;
    hold_d  = hold_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StBusy;
          gnt_d   = 8'b1 << win_id;
          id_d    = win_id;
          valid_d = 1'b1;
          last_d  = win_id;
          hold_d  = HOLD_W'(1);
        end else begin
          gnt_d   = '0;
          id_d    = '0;
          valid_d = 1'b0;
        end
      end
      StBusy: begin
        if (done || withdraw || wd_hit) begin
          state_d = StIdle;
          gnt_d   = '0;
          id_d    = '0;
          valid_d = 1'b0;
          // done wins over a coinciding watchdog limit
          tmo_d   = wd_hit && !done;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      id_q    <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Bench for req_arbiter: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the arbitration rules.
module tb_req_arbiter;

  localparam int unsigned MaxHold = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       rr_en;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit m_busy;
  int m_owner;
  int m_last;
  int m_held;
  bit m_tmo;

  req_arbiter #(
    .MAX_HOLD (MaxHold),
    .HOLD_W   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .rr_en     (rr_en),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 0; m_held = 0; m_tmo = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d, input logic rr);
    int start;
    m_tmo = 0;
    if (!m_busy) begin
      if (r != 0) begin
        start = rr ? m_last : 0;
        // first set bit walking downward from start-1, wrapping
        for (int k = 1; k <= 8; k++) begin
          if (!m_busy && r[(start - k + 16) % 8]) begin
            m_owner = (start - k + 16) % 8;
            m_busy  = 1;
          end
        end
        m_last = m_owner;
        m_held = 1;
      end
    end else begin
      if (d || !r[m_owner] || m_held == MaxHold) begin
        m_busy = 0;
        m_tmo  = (m_held == MaxHold) && !d;
      end else if (m_held < 255) begin
        m_held++;
      end
    end
  endtask

  task automatic tick(input logic [7:0] r, input logic d, input logic rr);
    req = r; done = d; rr_en = rr;
    @(posedge clk);
    model_step(r, d, rr);
    #1;
  endtask

  task automatic do_reset();
    req = '0; done = 1'b0; rr_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; done = 1'b0; rr_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== 13'h0) begin
      failures++;
      $display("FAIL reset_state: got gnt=%h id=%0d v=%b t=%b want all 0", gnt, gnt_id, gnt_valid,
               timeout);
    end
    rst_n = 1'b1;
    tick(8'hFF, 1'b0, 1'b1);
    tick(8'hFF, 1'b0, 1'b1);
    checks++;
    if (gnt !== 8'h80) begin
      failures++;
      $display("FAIL reset_pre_grant: got gnt=%h want 80", gnt);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== 13'h0) begin
      failures++;
      $display("FAIL reset_async: got gnt=%h id=%0d v=%b t=%b want all 0", gnt, gnt_id, gnt_valid,
               timeout);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(8'hFF, 1'b0, 1'b1);
    checks++;
    if (gnt !== 8'h80 || gnt_id !== 3'd7 || gnt_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_rr: got gnt=%h id=%0d v=%b want 80/7/1", gnt, gnt_id, gnt_valid);
    end
    tick(8'hFF, 1'b1, 1'b1);
  endtask

  task automatic test_fixed_priority();
    do_reset();
    tick(8'b0010_0110, 1'b0, 1'b0);
    checks++;
    if (gnt !== 8'b0010_0000 || gnt_id !== 3'd5) begin
      failures++;
      $display("FAIL fixed_grant: got gnt=%h id=%0d want 20/5", gnt, gnt_id);
    end
    tick(8'b0010_0110, 1'b1, 1'b0);
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      failures++;
      $display("FAIL fixed_release: got gnt=%h v=%b want 00/0", gnt, gnt_valid);
    end
    tick(8'b0010_0110, 1'b0, 1'b0);
    checks++;
    if (gnt_id !== 3'd5 || gnt_valid !== 1'b1) begin
      failures++;
      $display("FAIL fixed_regrant: got id=%0d v=%b want 5/1", gnt_id, gnt_valid);
    end
    tick(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    int exp_ids [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    do_reset();
    foreach (exp_ids[i]) begin
      tick(8'hFF, 1'b0, 1'b1);
      checks++;
      if (gnt_id !== 3'(exp_ids[i]) || gnt !== (8'b1 << exp_ids[i])) begin
        failures++;
        $display("FAIL rr_seq[%0d]: got gnt=%h id=%0d want id %0d", i, gnt, gnt_id, exp_ids[i]);
      end
      tick(8'hFF, 1'b0, 1'b1);
      tick(8'hFF, 1'b1, 1'b1);
      checks++;
      if (gnt !== 8'h00) begin
        failures++;
        $display("FAIL rr_gap[%0d]: got gnt=%h want 00", i, gnt);
      end
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    tick(8'h10, 1'b0, 1'b1);
    tick(8'h10, 1'b1, 1'b1);
    tick(8'h48, 1'b0, 1'b1);
    checks++;
    if (gnt_id !== 3'd3 || gnt !== 8'h08) begin
      failures++;
      $display("FAIL withdraw_grant3: got gnt=%h id=%0d want 08/3", gnt, gnt_id);
    end
    tick(8'h40, 1'b0, 1'b1);
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_release: got gnt=%h t=%b want 00/0", gnt, timeout);
    end
    tick(8'h40, 1'b0, 1'b1);
    checks++;
    if (gnt_id !== 3'd6 || gnt !== 8'h40) begin
      failures++;
      $display("FAIL withdraw_next: got gnt=%h id=%0d want 40/6", gnt, gnt_id);
    end
    tick(8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(8'h01, 1'b0, 1'b0);
      checks++;
      if (gnt !== 8'h01 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL wd_hold[%0d]: got gnt=%h t=%b want 01/0", i, gnt, timeout);
      end
    end
    tick(8'h01, 1'b0, 1'b0);
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b1) begin
      failures++;
      $display("FAIL wd_revoke: got gnt=%h t=%b want 00/1", gnt, timeout);
    end
    tick(8'h01, 1'b0, 1'b0);
    checks++;
    if (gnt !== 8'h01 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL wd_regrant: got gnt=%h t=%b want 01/0", gnt, timeout);
    end
    for (int i = 0; i < 3; i++) tick(8'h01, 1'b0, 1'b0);
    checks++;
    if (gnt !== 8'h01) begin
      failures++;
      $display("FAIL wd_done_hold: got gnt=%h want 01", gnt);
    end
    tick(8'h01, 1'b1, 1'b0);
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL wd_done_prio: got gnt=%h t=%b want 00/0", gnt, timeout);
    end
    tick(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_isolation();
    logic [4:0] hi [2] = '{5'b11111, 5'b01010};
    do_reset();
    tick(8'h04, 1'b0, 1'b0);
    foreach (hi[i]) begin
      tick({hi[i], 3'b100}, 1'b0, 1'b0);
      checks++;
      if (gnt !== 8'h04 || gnt_id !== 3'd2) begin
        failures++;
        $display("FAIL isolation[%0d]: got gnt=%h id=%0d want 04/2", i, gnt, gnt_id);
      end
    end
    tick(8'hFC, 1'b1, 1'b0);
    checks++;
    if (gnt !== 8'h00) begin
      failures++;
      $display("FAIL isolation_done: got gnt=%h want 00", gnt);
    end
    tick(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       rr;
    logic [7:0] eg;
    do_reset();
    r  = 8'h00;
    rr = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(4) == 0) r = 8'($urandom);
      if ($urandom_range(9) == 0) rr = ~rr;
      tick(r, ($urandom_range(5) == 0), rr);
      eg = m_busy ? (8'b1 << m_owner) : 8'h00;
      checks++;
      if (gnt !== eg || gnt_id !== (m_busy ? 3'(m_owner) : 3'd0) || gnt_valid !== m_busy ||
          timeout !== m_tmo) begin
        failures++;
        $display("FAIL random[%0d]: got gnt=%h id=%0d v=%b t=%b want gnt=%h v=%b t=%b", n, gnt,
                 gnt_id, gnt_valid, timeout, eg, m_busy, m_tmo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_withdraw();
    test_watchdog();
    test_isolation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
